// File: rtl/mc_control_fsm_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle control FSM.
// Holds the state enum, ALUControl encodings, Op and cmd codes, and the
// datapath select encodings used by mc_control_fsm and alu_dec.
// Optional feature macro: MC_CTRL_CMP_EN (adds CMP, cmd 1010).

package mc_ctrl_pkg;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  // ALUControl encodings
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  // Op field (instruction[27:26])
  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_UNDEF  = 2'b11;

  // Data-processing cmd field (Funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Per-state control bundle decoded from the state register
  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

  // RegSrc is a pure function of Op: [1] for memory (store data from Rd),
  // [0] for branch (PC as A operand source register).
  function automatic logic [1:0] reg_src_of(input logic [1:0] op);
    return {op == OP_MEM, op == OP_BRANCH};
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_dec.sv
// alu_dec: combinational ALU decoder for data-processing instructions.
// Maps cmd/S plus an ALU-op enable to ALUControl, FlagW, a supported flag
// and whether the result is written back to Rd.
// Optional feature macro: MC_CTRL_CMP_EN (CMP decodes as SUB, flags only).

module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cmd,
  input  logic       s_bit,
  input  logic       alu_op,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       supported,
  output logic       writes_rd
);

  logic arith;

  // Decode the command; everything stays zero unless an ALU op is active
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    supported   = 1'b0;
    writes_rd   = 1'b0;
    arith       = 1'b0;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin
          alu_control = ALU_ADD;
          supported   = 1'b1;
          writes_rd   = 1'b1;
          arith       = 1'b1;
        end
        CMD_SUB: begin
          alu_control = ALU_SUB;
          supported   = 1'b1;
          writes_rd   = 1'b1;
          arith       = 1'b1;
        end
        CMD_AND: begin
          alu_control = ALU_AND;
          supported   = 1'b1;
          writes_rd   = 1'b1;
        end
        CMD_ORR: begin
          alu_control = ALU_ORR;
          supported   = 1'b1;
          writes_rd   = 1'b1;
        end
`ifdef MC_CTRL_CMP_EN
        // CMP subtracts to set flags but never writes Rd
        CMD_CMP: begin
          alu_control = ALU_SUB;
          supported   = 1'b1;
          writes_rd   = 1'b0;
          arith       = 1'b1;
        end
`endif
        default: begin
          alu_control = ALU_ADD;
        end
      endcase
      // C/V are only meaningful for add/subtract; unsupported cmds write no flags
      if (supported) begin
        flag_w = {s_bit, s_bit & arith};
      end
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: main controller of a multicycle ARM-subset datapath.
// A single state register sequences FETCH/DECODE/execute states; all outputs
// are decoded from the state and the current Op/Funct/Rd with no extra
// latency. The active-low reset also blanks every write/update request.
// Optional feature macro: MC_CTRL_CMP_EN (CMP support in alu_dec).

module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  state_e     state_q;
  state_e     state_d;
  ctrl_t      ctrl;
  logic       alu_op;
  logic [1:0] dec_alu_control;
  logic [1:0] dec_flag_w;
  logic       dec_supported;
  logic       dec_writes_rd;
  logic       run;
  logic       rd_is_pc;

  assign alu_op   = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign run      = reset;
  assign rd_is_pc = (Rd == 4'hF);

  alu_dec u_alu_dec (
    .cmd         (Funct[4:1]),
    .s_bit       (Funct[0]),
    .alu_op      (alu_op),
    .alu_control (dec_alu_control),
    .flag_w      (dec_flag_w),
    .supported   (dec_supported),
    .writes_rd   (dec_writes_rd)
  );

  // Next-state selection from the current state and instruction fields
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_MEM:    state_d = S_MEMADR;
          OP_DP:     state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_BRANCH: state_d = S_BRANCH;
          OP_UNDEF:  state_d = S_FETCH;
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      // Unsupported commands and flag-only commands skip write-back
      S_EXECR,
      S_EXECI:  state_d = (dec_supported && dec_writes_rd) ? S_ALUWB : S_FETCH;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction and restarts at FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge value of its inputs.
      state_q <= state_d;
    end
  end

  // Moore decode of the per-state datapath controls
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      S_MEMADR: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWR: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_w      = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_REG;
      end
      S_EXECI: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  // Write/update requests are blanked while reset is held low
  assign IRWrite = ctrl.ir_write & run;
  assign NextPC  = ctrl.next_pc  & run;
  assign RegW    = ctrl.reg_w    & run;
  assign MemW    = ctrl.mem_w    & run;
  assign PCS     = (ctrl.branch | (ctrl.reg_w & rd_is_pc)) & run;
  assign FlagW   = dec_flag_w & {2{run}};

  // Datapath selects
  assign AdrSrc     = ctrl.adr_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ResultSrc  = ctrl.result_src;
  assign ALUControl = dec_alu_control;

  // Immediate and register-source selects follow the instruction directly
  assign ImmSrc = Op;
  assign RegSrc = reg_src_of(Op);

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: scoreboard bench for mc_control_fsm.
// The driver applies one directed vector per cycle (just after the rising
// edge) and queues the hand-derived expected outputs; the monitor pops and
// compares on every falling edge. Expectations for CMP follow MC_CTRL_CMP_EN.

module tb_mc_control_fsm;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       pcs;
    logic [1:0] flag_w;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
  } outs_t;

  localparam int T_FETCH  = 0;
  localparam int T_DECODE = 1;
  localparam int T_MEMADR = 2;
  localparam int T_MEMRD  = 3;
  localparam int T_MEMWB  = 4;
  localparam int T_MEMWR  = 5;
  localparam int T_EXECR  = 6;
  localparam int T_EXECI  = 7;
  localparam int T_ALUWB  = 8;
  localparam int T_BRANCH = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b000000;
  logic [3:0] rd = 4'h0;

  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  outs_t exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (op),
    .Funct      (funct),
    .Rd         (rd),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  // Expected per-state outputs, written out from the state table
  function automatic outs_t base(input int st, input logic [1:0] o, input logic [3:0] r);
    outs_t e;
    e = '0;
    case (st)
      T_FETCH:  begin e.ir_write = 1; e.next_pc = 1; e.alu_src_a = 1;
                      e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      T_DECODE: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      T_MEMADR: begin e.alu_src_b = 2'b01; end
      T_MEMRD:  begin e.adr_src = 1; end
      T_MEMWR:  begin e.adr_src = 1; e.mem_w = 1; end
      T_MEMWB:  begin e.result_src = 2'b01; e.reg_w = 1; e.pcs = (r == 4'hF); end
      T_ALUWB:  begin e.reg_w = 1; e.pcs = (r == 4'hF); end
      T_EXECR:  begin e.alu_src_b = 2'b00; end
      T_EXECI:  begin e.alu_src_b = 2'b01; end
      T_BRANCH: begin e.alu_src_b = 2'b01; e.result_src = 2'b10; e.pcs = 1; end
      default:  begin e = '0; end
    endcase
    e.imm_src = o;
    e.reg_src = {o == 2'b01, o == 2'b10};
    return e;
  endfunction

  // One running cycle: drive the instruction fields and queue the expectation
  task automatic step(input int st, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] r, input logic [1:0] fw, input logic [1:0] ac,
                      input string nm);
    outs_t e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    op    = o;
    funct = f;
    rd    = r;
    e = base(st, o, r);
    e.flag_w      = fw;
    e.alu_control = ac;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One cycle with reset held low: state is FETCH but requests are blanked
  task automatic rst_cycle(input string nm);
    outs_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    e = base(T_FETCH, op, rd);
    e.ir_write = 0;
    e.next_pc  = 0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        outs_t e;
        outs_t g;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = {IRWrite, NextPC, RegW, MemW, PCS, FlagW, AdrSrc, ALUSrcA,
              ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
        n_vec++;
        if (g !== e) begin
          n_miss++;
          $display("FAIL %s: got %b expected %b (ir,npc,regw,memw,pcs,flagw,adr,srca,srcb,res,aluctl,imm,regsrc)",
                   nm, g, e);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    logic [1:0] cmp_fw;
    logic [1:0] cmp_ac;
`ifdef MC_CTRL_CMP_EN
    cmp_fw = 2'b11;
    cmp_ac = 2'b01;
`else
    cmp_fw = 2'b00;
    cmp_ac = 2'b00;
`endif

    // Reset held for three cycles, then released into FETCH
    rst_cycle("rst.c1");
    rst_cycle("rst.c2");
    rst_cycle("rst.c3");

    // LDR R15: five cycles, write-back to PC raises PCS
    step(T_FETCH,  2'b01, 6'b011001, 4'hF, 2'b00, 2'b00, "ldr.fetch");
    step(T_DECODE, 2'b01, 6'b011001, 4'hF, 2'b00, 2'b00, "ldr.decode");
    step(T_MEMADR, 2'b01, 6'b011001, 4'hF, 2'b00, 2'b00, "ldr.memadr");
    step(T_MEMRD,  2'b01, 6'b011001, 4'hF, 2'b00, 2'b00, "ldr.memrd");
    step(T_MEMWB,  2'b01, 6'b011001, 4'hF, 2'b00, 2'b00, "ldr.memwb");

    // STR: four cycles, MemW in MEMWR
    step(T_FETCH,  2'b01, 6'b011000, 4'h3, 2'b00, 2'b00, "str.fetch");
    step(T_DECODE, 2'b01, 6'b011000, 4'h3, 2'b00, 2'b00, "str.decode");
    step(T_MEMADR, 2'b01, 6'b011000, 4'h3, 2'b00, 2'b00, "str.memadr");
    step(T_MEMWR,  2'b01, 6'b011000, 4'h3, 2'b00, 2'b00, "str.memwr");

    // ADDS register: FlagW=11, ALUControl=00
    step(T_FETCH,  2'b00, 6'b001001, 4'h2, 2'b00, 2'b00, "adds.fetch");
    step(T_DECODE, 2'b00, 6'b001001, 4'h2, 2'b00, 2'b00, "adds.decode");
    step(T_EXECR,  2'b00, 6'b001001, 4'h2, 2'b11, 2'b00, "adds.execr");
    step(T_ALUWB,  2'b00, 6'b001001, 4'h2, 2'b00, 2'b00, "adds.aluwb");

    // SUB immediate, no S, Rd=R15: ALUControl=01, no flags, PCS on write-back
    step(T_FETCH,  2'b00, 6'b100100, 4'hF, 2'b00, 2'b00, "subi.fetch");
    step(T_DECODE, 2'b00, 6'b100100, 4'hF, 2'b00, 2'b00, "subi.decode");
    step(T_EXECI,  2'b00, 6'b100100, 4'hF, 2'b00, 2'b01, "subi.execi");
    step(T_ALUWB,  2'b00, 6'b100100, 4'hF, 2'b00, 2'b00, "subi.aluwb");

    // ANDS register: logical op sets NZ only
    step(T_FETCH,  2'b00, 6'b000001, 4'h1, 2'b00, 2'b00, "ands.fetch");
    step(T_DECODE, 2'b00, 6'b000001, 4'h1, 2'b00, 2'b00, "ands.decode");
    step(T_EXECR,  2'b00, 6'b000001, 4'h1, 2'b10, 2'b10, "ands.execr");
    step(T_ALUWB,  2'b00, 6'b000001, 4'h1, 2'b00, 2'b00, "ands.aluwb");

    // ORRS immediate
    step(T_FETCH,  2'b00, 6'b111001, 4'h4, 2'b00, 2'b00, "orrs.fetch");
    step(T_DECODE, 2'b00, 6'b111001, 4'h4, 2'b00, 2'b00, "orrs.decode");
    step(T_EXECI,  2'b00, 6'b111001, 4'h4, 2'b10, 2'b11, "orrs.execi");
    step(T_ALUWB,  2'b00, 6'b111001, 4'h4, 2'b00, 2'b00, "orrs.aluwb");

    // Branch: three cycles, PCS in BRANCH
    step(T_FETCH,  2'b10, 6'b000000, 4'h0, 2'b00, 2'b00, "b.fetch");
    step(T_DECODE, 2'b10, 6'b000000, 4'h0, 2'b00, 2'b00, "b.decode");
    step(T_BRANCH, 2'b10, 6'b000000, 4'h0, 2'b00, 2'b00, "b.branch");

    // CMP: flags depend on the build, never a write-back
    step(T_FETCH,  2'b00, 6'b010101, 4'h5, 2'b00, 2'b00, "cmp.fetch");
    step(T_DECODE, 2'b00, 6'b010101, 4'h5, 2'b00, 2'b00, "cmp.decode");
    step(T_EXECR,  2'b00, 6'b010101, 4'h5, cmp_fw, cmp_ac, "cmp.execr");

    // Unsupported cmd 1111: EXECR then straight back to FETCH
    step(T_FETCH,  2'b00, 6'b011111, 4'h6, 2'b00, 2'b00, "cmd15.fetch");
    step(T_DECODE, 2'b00, 6'b011111, 4'h6, 2'b00, 2'b00, "cmd15.decode");
    step(T_EXECR,  2'b00, 6'b011111, 4'h6, 2'b00, 2'b00, "cmd15.execr");

    // Undefined Op: two cycles
    step(T_FETCH,  2'b11, 6'b000000, 4'h7, 2'b00, 2'b00, "undef.fetch");
    step(T_DECODE, 2'b11, 6'b000000, 4'h7, 2'b00, 2'b00, "undef.decode");

    // LDR aborted by reset in MEMADR; restart at FETCH
    step(T_FETCH,  2'b01, 6'b011001, 4'hF, 2'b00, 2'b00, "abort.fetch");
    step(T_DECODE, 2'b01, 6'b011001, 4'hF, 2'b00, 2'b00, "abort.decode");
    step(T_MEMADR, 2'b01, 6'b011001, 4'hF, 2'b00, 2'b00, "abort.memadr");
    rst_cycle("abort.rst1");
    rst_cycle("abort.rst2");
    step(T_FETCH,  2'b11, 6'b000000, 4'h0, 2'b00, 2'b00, "abort.refetch");
    step(T_DECODE, 2'b11, 6'b000000, 4'h0, 2'b00, 2'b00, "abort.decode2");
    step(T_FETCH,  2'b11, 6'b000000, 4'h0, 2'b00, 2'b00, "end.fetch");

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameters: none; all widths are fixed by the ISA subset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Op  in  2  instruction[27:26]; 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  in  6  instruction[25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) or L (memory).
REQ-006 Rd  in  4  destination register field.
REQ-007 FlagW  out  2  flag-write request to conditional logic: [1]=NZ, [0]=CV.
REQ-008 PCS  out  1  PC-source request (branch, or write to R15).
REQ-009 NextPC  out  1  unconditional PC update in FETCH.
REQ-010 RegW, MemW, IRWrite  out  1 each  register, memory and IR write requests.
REQ-011 AdrSrc, ALUSrcA  out  1 each  address mux and ALU A-operand mux selects.
REQ-012 ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects.
REQ-013 State register and all outputs are in the clk domain; reset is asynchronous and active-low.

Function
REQ-014 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-015 FETCH->DECODE unconditionally.
REQ-016 DECODE transitions: Op=01 goes to MEMADR; Op=00 with Funct[5]=0 goes to EXECR; Op=00 with Funct[5]=1 goes to EXECI; Op=10 goes to BRANCH; Op=11 goes to FETCH.
REQ-017 MEMADR transitions: Funct[0]=1 goes to MEMRD; otherwise MEMWR.
REQ-018 Sequences: MEMRD->MEMWB->FETCH; MEMWR->FETCH; BRANCH->FETCH.
REQ-019 EXECR/EXECI->ALUWB->FETCH for supported cmd; unsupported cmd goes to FETCH directly, with no write.
REQ-020 FETCH outputs: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00.
REQ-021 DECODE outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00; all write enables 0.
REQ-022 MEMADR outputs: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
REQ-023 MEMRD outputs: AdrSrc=1, ResultSrc=00. MEMWR outputs: AdrSrc=1, ResultSrc=00, MemW=1.
REQ-024 MEMWB outputs: ResultSrc=01, RegW=1. ALUWB outputs: ResultSrc=00, RegW=1.
REQ-025 EXECR outputs: ALUSrcA=0, ALUSrcB=00, ALU-decode active. EXECI: as EXECR, but ALUSrcB=01.
REQ-026 BRANCH outputs: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, branch=1.
REQ-027 ALU decode on cmd: ADD 0100 gives ALUControl 00; SUB 0010 gives 01; AND 0000 gives 10; ORR 1100 gives 11.
REQ-028 FlagW[1] = S; FlagW[0] = S & (ADD|SUB); these values are asserted only in EXECR/EXECI, and FlagW=00 in all other states.
REQ-029 PCS = branch | (RegW & Rd==4'hF), evaluated in the same cycle as RegW (MEMWB, ALUWB).
REQ-030 ImmSrc = Op; RegSrc[0] = (Op==10); RegSrc[1] = (Op==01). Both are combinational on inputs.
REQ-031 All outputs are Moore decode of state, plus Op/Funct/Rd; there is no output register and no extra latency.
REQ-032 Unlisted outputs in any state are 0.
REQ-033 Instruction latency is fixed at: LDR 5 cycles, STR 4, DP 4, branch 3, undefined 2.

Reset
REQ-034 reset low immediately forces state=FETCH.
REQ-035 While reset is low, IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced to 0.
REQ-036 Reset asserted mid-instruction aborts the instruction; the first cycle after release is FETCH with IRWrite=1.

Configuration
REQ-037 Macro MC_CTRL_CMP_EN enables CMP.
REQ-038 With MC_CTRL_CMP_EN defined, cmd 1010 gives ALUControl=01 and FlagW=11 (when S=1), and EXECR/EXECI go to FETCH without ALUWB.
REQ-039 Without MC_CTRL_CMP_EN, cmd 1010 is unsupported: FlagW=00 and the FSM goes to FETCH.

Structure
REQ-040 Package mc_ctrl_pkg holds the state enum, the ALUControl encodings, the Op codes and the cmd codes.
REQ-041 Sub-module alu_dec (combinational) maps Funct plus an ALU-op enable to ALUControl, FlagW and a supported flag.

Verification
REQ-042 Reset low 3 cycles, then release: cycle 1 is FETCH with IRWrite=1 and NextPC=1, and RegW=MemW=0 throughout reset.
REQ-043 LDR (Op=01, Funct=011001): states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegW=1 only in cycle 5; with Rd=F, PCS=1 in cycle 5.
REQ-044 ADDS register (Op=00, Funct=001001): EXECR gives ALUControl=00, FlagW=11; ALUWB gives RegW=1; total 4 cycles.
REQ-045 Branch (Op=10): BRANCH cycle gives PCS=1, ALUSrcB=01; back to FETCH on cycle 4.
REQ-046 CMP (Op=00, Funct=010101): with the macro, FlagW=11 and no RegW; without the macro, FlagW=00, RegW never 1.
REQ-047 Op=11 or cmd=1111: FETCH then DECODE or EXEC then FETCH; no write enable ever asserted.
